// File: rtl/ddr_mmap_apb_bridge.sv
// Single-outstanding bridge from a valid/ready memory-mapped request port to a 5-slave APB bus.
// Optional ACCESS-phase watchdog is compiled in with `define DDR_APB_TIMEOUT_EN.
module ddr_mmap_apb_bridge #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_write,
    input  logic [31:0]  i_req_addr,
    input  logic [31:0]  i_req_wdata,
    input  logic [3:0]   i_req_wstrb,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [31:0]  o_rsp_rdata,
    output logic [1:0]   o_rsp_resp,
    output logic [4:0]   o_psel,
    output logic         o_penable,
    output logic         o_pwrite,
    output logic [31:0]  o_paddr,
    output logic [31:0]  o_pwdata,
    output logic [3:0]   o_pstrb,
    input  logic [4:0]   i_pready,
    input  logic [159:0] i_prdata,
    input  logic [4:0]   i_pslverr
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  sel_r;
    logic [2:0]  idx_r;
    logic        pwrite_r;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic [3:0]  pstrb_r;
    logic [31:0] rdata_r;
    logic [1:0]  resp_r;

    logic        dec_hit;
    logic [2:0]  dec_idx;
    logic [31:0] dec_base;
    logic [31:0] dec_off;

    logic        load_req;
    logic        load_rsp;
    logic [31:0] rsp_rdata_nxt;
    logic [1:0]  rsp_resp_nxt;

    logic        slave_ready;
    logic        slave_err;
    logic [31:0] slave_rdata;
    logic        apb_phase;

    // Region map: [base, base+size); anything else decodes as a miss.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_base = '0;
        if (i_req_addr < 32'h0000_4000) begin
            dec_hit  = 1'b1;
            dec_idx  = 3'd0;
            dec_base = 32'h0000_0000;
        end else if (i_req_addr < 32'h0000_8000) begin
            dec_hit  = 1'b1;
            dec_idx  = 3'd1;
            dec_base = 32'h0000_4000;
        end else if (i_req_addr < 32'h0001_0000) begin
            dec_hit  = 1'b1;
            dec_idx  = 3'd2;
            dec_base = 32'h0000_8000;
        end else if (i_req_addr >= 32'h0009_0000 && i_req_addr < 32'h0016_0000) begin
            dec_hit  = 1'b1;
            dec_idx  = 3'd3;
            dec_base = 32'h0009_0000;
        end else if (i_req_addr >= 32'h0100_0000 && i_req_addr < 32'h0200_0000) begin
            dec_hit  = 1'b1;
            dec_idx  = 3'd4;
            dec_base = 32'h0100_0000;
        end
        dec_off = i_req_addr - dec_base;
    end

    // Only the selected slave's ready/error/data lanes are ever looked at.
    assign slave_ready = |(i_pready & sel_r);
    assign slave_err   = |(i_pslverr & sel_r);

    always_comb begin
        slave_rdata = '0;
        for (int unsigned n = 0; n < 5; n++) begin
            if (idx_r == 3'(n)) begin
                slave_rdata = i_prdata[n*32 +: 32];
            end
        end
    end

`ifdef DDR_APB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] to_cnt;
    logic          timed_out;

    assign timed_out = (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !timed_out) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_req      = 1'b0;
        load_rsp      = 1'b0;
        rsp_rdata_nxt = '0;
        rsp_resp_nxt  = RESP_OKAY;
        case (state)
            IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    load_req = 1'b1;
                    if (dec_hit) begin
                        state_nxt = SETUP;
                    end else begin
                        load_rsp     = 1'b1;
                        rsp_resp_nxt = RESP_DECERR;
                        state_nxt    = RESP;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (slave_ready) begin
                    load_rsp      = 1'b1;
                    rsp_rdata_nxt = pwrite_r ? '0 : slave_rdata;
                    rsp_resp_nxt  = slave_err ? RESP_SLVERR : RESP_OKAY;
                    state_nxt     = RESP;
                end
`ifdef DDR_APB_TIMEOUT_EN
                else if (timed_out) begin
                    load_rsp     = 1'b1;
                    rsp_resp_nxt = RESP_SLVERR;
                    state_nxt    = RESP;
                end
`endif
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_r    <= '0;
            idx_r    <= '0;
            pwrite_r <= 1'b0;
            paddr_r  <= '0;
            pwdata_r <= '0;
            pstrb_r  <= '0;
            rdata_r  <= '0;
            resp_r   <= RESP_OKAY;
        end else begin
            if (load_req) begin
                sel_r    <= dec_hit ? (5'b00001 << dec_idx) : '0;
                idx_r    <= dec_idx;
                pwrite_r <= i_req_write;
                paddr_r  <= {dec_off[31:2], 2'b00};
                pwdata_r <= i_req_wdata;
                pstrb_r  <= i_req_write ? i_req_wstrb : '0;
            end
            if (load_rsp) begin
                rdata_r <= rsp_rdata_nxt;
                resp_r  <= rsp_resp_nxt;
            end
        end
    end

    // Outputs are gated by state, so an async reset forcing IDLE clears them at once.
    assign apb_phase   = (state == SETUP) || (state == ACCESS);
    assign o_req_ready = (state == IDLE) && !i_rst;
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_rdata = (state == RESP) ? rdata_r : '0;
    assign o_rsp_resp  = (state == RESP) ? resp_r : '0;
    assign o_psel      = apb_phase ? sel_r : '0;
    assign o_penable   = (state == ACCESS);
    assign o_pwrite    = apb_phase ? pwrite_r : 1'b0;
    assign o_paddr     = apb_phase ? paddr_r : '0;
    assign o_pwdata    = apb_phase ? pwdata_r : '0;
    assign o_pstrb     = apb_phase ? pstrb_r : '0;

endmodule
